projectile_pool: RTL

- Parametrised projectile engine for the ranged weapon: a pool of PROJ_COUNT independent projectile slots.
- Spawns a projectile on fire, aimed from the weapon origin toward the mouse, with a frame-based cooldown.
- Moves every live projectile once per frame_tick; retires a projectile on screen exit, lifetime expiry or boss hit. Reports hits and a running hit count.
- Sits between the mouse/weapon-position logic and the projectile sprite drawer and boss health logic. Generalises the fixed-count projectile animator with direction vectors, lifetime, cooldown and hit counting.

---
 rtl/projectile_pool.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/projectile_pool.sv
// projectile_pool
// Pool of PROJ_COUNT projectile slots for the ranged weapon. A rising edge of
// fire (while ready) spawns a projectile at the weapon origin, aimed at the
// mouse. Every live projectile moves once per frame_tick. It is retired when it
// leaves the screen or when its lifetime runs out. One cycle after each tick the
// stored positions are tested against the boss hitbox. Hitting slots are
// cleared and counted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   game_active       2'b01 while gameplay runs
//   alive, enable     player alive / ranged class selected
//   fire              mouse button level (edge-detected internally)
//   origin_x/y        spawn point (weapon tip), 12 bit
//   target_x/y        mouse position, 12 bit
//   boss_alive        boss present
//   boss_x/y          boss centre, 12 bit
//   pos_x_proj/y      packed slot positions, slot i at [12i+11:12i]
//   proj_active       slot live flags
//   hit_pulse         one-cycle pulse when at least one slot hit the boss
//   hit_count         saturating total of hits
//   ready             a fire edge would be accepted this cycle
module projectile_pool #(
    parameter int PROJ_COUNT      = 4,
    parameter int SPEED           = 8,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int LIFETIME_FRAMES = 90,
    parameter int SCREEN_W        = 1024,
    parameter int SCREEN_H        = 768,
    parameter int HIT_HALF_W      = 40,
    parameter int HIT_HALF_H      = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [1:0]               game_active,
    input  logic                     alive,
    input  logic                     enable,
    input  logic                     fire,
    input  logic [11:0]              origin_x,
    input  logic [11:0]              origin_y,
    input  logic [11:0]              target_x,
    input  logic [11:0]              target_y,
    input  logic                     boss_alive,
    input  logic [11:0]              boss_x,
    input  logic [11:0]              boss_y,
    output logic [PROJ_COUNT*12-1:0] pos_x_proj,
    output logic [PROJ_COUNT*12-1:0] pos_y_proj,
    output logic [PROJ_COUNT-1:0]    proj_active,
    output logic                     hit_pulse,
    output logic [7:0]               hit_count,
    output logic                     ready
);

    localparam int IDX_W = (PROJ_COUNT > 1) ? $clog2(PROJ_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Magnitude of a 13-bit two's-complement value.
    function automatic logic [12:0] abs13(input logic [12:0] v);
        abs13 = v[12] ? (13'd0 - v) : v;
    endfunction

    // Number of set bits in a slot flag vector.
    function automatic logic [4:0] count_bits(input logic [PROJ_COUNT-1:0] v);
        count_bits = 5'd0;
        for (int i = 0; i < PROJ_COUNT; i++) begin
            count_bits = count_bits + 5'(v[i]);
        end
    endfunction

    state_t             state_r, state_next_s;
    logic               fire_d_r;
    logic               tick_d_r;
    logic [15:0]        cooldown_r;
    logic signed [12:0] dx_r, dy_r;
    logic [11:0]        ox_r, oy_r;
    logic [7:0]         vx_calc_r, vy_calc_r;
    logic               hit_pulse_r;
    logic [7:0]         hit_count_r;

    logic [11:0]        pos_x_r [PROJ_COUNT];
    logic [11:0]        pos_y_r [PROJ_COUNT];
    logic [7:0]         vel_x_r [PROJ_COUNT];
    logic [7:0]         vel_y_r [PROJ_COUNT];
    logic [7:0]         life_r  [PROJ_COUNT];
    logic [PROJ_COUNT-1:0] active_r;

    logic               run_s, fire_edge_s, any_free_s, ready_s, load_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic [12:0]        mag_x_s, mag_y_s, mag_s;
    logic [3:0]         shift_s;
    logic [7:0]         vx_s, vy_s;
    logic [12:0]        nx_s [PROJ_COUNT];
    logic [12:0]        ny_s [PROJ_COUNT];
    logic [PROJ_COUNT-1:0] retire_s;
    logic [PROJ_COUNT-1:0] hit_s;
    logic [8:0]         hit_sum_s;

    assign run_s       = (game_active == 2'b01) && alive && enable;
    assign fire_edge_s = fire && !fire_d_r;
    assign any_free_s  = !(&active_r);
    assign ready_s     = !rst && run_s && (state_r == IDLE) &&
                         (cooldown_r == 16'd0) && any_free_s;
    assign load_s      = (state_r == LOAD) && run_s && any_free_s;

    // Spawn FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fire_edge_s && ready_s) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (run_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Spawn FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Velocity: shift the delta right until its larger axis fits within SPEED.
    always_comb begin
        mag_x_s = abs13(dx_r);
        mag_y_s = abs13(dy_r);
        if (mag_x_s >= mag_y_s) begin
            mag_s = mag_x_s;
        end else begin
            mag_s = mag_y_s;
        end
        // Walk downward so the last match is the smallest shift.
        shift_s = 4'd12;
        for (int k = 12; k >= 0; k--) begin
            if ((mag_s >> k) <= 13'(SPEED)) begin
                shift_s = 4'(k);
            end else begin
                shift_s = shift_s;
            end
        end
        if (dx_r == 13'sd0 && dy_r == 13'sd0) begin
            vx_s = 8'(SPEED);
            vy_s = 8'd0;
        end else begin
            vx_s = 8'(dx_r >>> shift_s);
            vy_s = 8'(dy_r >>> shift_s);
        end
    end

    // Lowest-index free slot. The loop runs downward so the last match wins.
    always_comb begin
        free_idx_s = '0;
        for (int i = PROJ_COUNT - 1; i >= 0; i--) begin
            if (!active_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Per-slot next position, retire decision and boss hit test.
    always_comb begin
        for (int i = 0; i < PROJ_COUNT; i++) begin
            nx_s[i] = {1'b0, pos_x_r[i]} + {{5{vel_x_r[i][7]}}, vel_x_r[i]};
            ny_s[i] = {1'b0, pos_y_r[i]} + {{5{vel_y_r[i][7]}}, vel_y_r[i]};
            retire_s[i] = nx_s[i][12] || (nx_s[i] >= 13'(SCREEN_W)) ||
                          ny_s[i][12] || (ny_s[i] >= 13'(SCREEN_H)) ||
                          (life_r[i] == 8'd1);
            hit_s[i] = active_r[i] && boss_alive &&
                       (abs13({1'b0, pos_x_r[i]} - {1'b0, boss_x}) <= 13'(HIT_HALF_W)) &&
                       (abs13({1'b0, pos_y_r[i]} - {1'b0, boss_y}) <= 13'(HIT_HALF_H));
        end
        hit_sum_s = {1'b0, hit_count_r} + 9'(count_bits(hit_s));
    end

    // Fire edge detector, tick delay for the collision stage, and spawn latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_d_r  <= 1'b0;
            tick_d_r  <= 1'b0;
            dx_r      <= 13'sd0;
            dy_r      <= 13'sd0;
            ox_r      <= 12'd0;
            oy_r      <= 12'd0;
            vx_calc_r <= 8'd0;
            vy_calc_r <= 8'd0;
        end else begin
            fire_d_r <= fire;
            tick_d_r <= frame_tick;
            if (state_r == IDLE && fire_edge_s && ready_s) begin
                dx_r <= {1'b0, target_x} - {1'b0, origin_x};
                dy_r <= {1'b0, target_y} - {1'b0, origin_y};
                ox_r <= origin_x;
                oy_r <= origin_y;
            end
            if (state_r == CALC) begin
                vx_calc_r <= vx_s;
                vy_calc_r <= vy_s;
            end
        end
    end

    // Spawn cooldown counter, counted in frame ticks.
    always_ff @(posedge clk) begin
        if (rst || !run_s) begin
            cooldown_r <= 16'd0;
        end else if (load_s) begin
            cooldown_r <= 16'(COOLDOWN_FRAMES);
        end else if (frame_tick && cooldown_r != 16'd0) begin
            cooldown_r <= cooldown_r - 16'd1;
        end
    end

    // Slot state: spawn, movement on tick, clearing on hit one cycle later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PROJ_COUNT; i++) begin
            if (rst || !run_s) begin
                pos_x_r[i]  <= 12'd0;
                pos_y_r[i]  <= 12'd0;
                vel_x_r[i]  <= 8'd0;
                vel_y_r[i]  <= 8'd0;
                life_r[i]   <= 8'd0;
                active_r[i] <= 1'b0;
            end else if (load_s && free_idx_s == IDX_W'(i)) begin
                pos_x_r[i]  <= ox_r;
                pos_y_r[i]  <= oy_r;
                vel_x_r[i]  <= vx_calc_r;
                vel_y_r[i]  <= vy_calc_r;
                life_r[i]   <= 8'(LIFETIME_FRAMES);
                active_r[i] <= 1'b1;
            end else if (frame_tick && active_r[i]) begin
                if (retire_s[i]) begin
                    pos_x_r[i]  <= 12'd0;
                    pos_y_r[i]  <= 12'd0;
                    life_r[i]   <= 8'd0;
                    active_r[i] <= 1'b0;
                end else begin
                    pos_x_r[i] <= nx_s[i][11:0];
                    pos_y_r[i] <= ny_s[i][11:0];
                    life_r[i]  <= life_r[i] - 8'd1;
                end
            end else if (tick_d_r && hit_s[i]) begin
                pos_x_r[i]  <= 12'd0;
                pos_y_r[i]  <= 12'd0;
                life_r[i]   <= 8'd0;
                active_r[i] <= 1'b0;
            end
        end
    end

    // Hit pulse and saturating hit counter. The counter holds while not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_pulse_r <= 1'b0;
            hit_count_r <= 8'd0;
        end else if (!run_s) begin
            hit_pulse_r <= 1'b0;
        end else if (tick_d_r) begin
            hit_pulse_r <= |hit_s;
            hit_count_r <= hit_sum_s[8] ? 8'hFF : hit_sum_s[7:0];
        end else begin
            hit_pulse_r <= 1'b0;
        end
    end

    // Pack slot positions onto the output buses.
    always_comb begin
        pos_x_proj = '0;
        pos_y_proj = '0;
        for (int i = 0; i < PROJ_COUNT; i++) begin
            pos_x_proj[12*i +: 12] = pos_x_r[i];
            pos_y_proj[12*i +: 12] = pos_y_r[i];
        end
    end

    assign proj_active = active_r;
    assign hit_pulse   = hit_pulse_r;
    assign hit_count   = hit_count_r;
    assign ready       = ready_s;

endmodule
